tomasulo_core: RTL and testbench

Single-issue, out-of-order integer core using Tomasulo's algorithm: register renaming through reservation-station tags, an adder and a multiplier, and one common data bus (CDB). An internal 16-entry instruction memory is indexed by an externally driven `pc`, so a driver can step a program through the core. Debug and CDB ports give a bench full visibility of architectural state.

---
 rtl/tomasulo_core.sv | 260 ++++++++++++++++++++++++++
 tb/tb_tomasulo_core.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tomasulo_core.sv
// Single-issue out-of-order integer core (Tomasulo): three ADD/SUB and two
// MUL reservation stations, one adder, one multiplier, one shared CDB.
// Ports: clk1/rst_n (sync, active-low); pc/issue_en offer imem[pc];
// imem_we/imem_waddr/imem_wdata load the 16-word imem (also during reset);
// stall = no free station for the offered class; cdb_* = current broadcast;
// dbg_raddr -> dbg_rdata/dbg_tag read one register's value and status tag.
module tomasulo_core (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic [3:0]  pc,
    input  logic        issue_en,
    input  logic        imem_we,
    input  logic [3:0]  imem_waddr,
    input  logic [15:0] imem_wdata,
    output logic        stall,
    output logic        cdb_valid,
    output logic [2:0]  cdb_tag,
    output logic [15:0] cdb_value,
    input  logic [3:0]  dbg_raddr,
    output logic [15:0] dbg_rdata,
    output logic [2:0]  dbg_tag
);

    logic [15:0] imem_q [16];
    logic [15:0] rval_q [16];
    logic [2:0]  rtag_q [16];

    // Station i carries tag i+1: 0..2 are ADD/SUB, 3..4 are MUL.
    logic        rs_busy_q [5];
    logic        rs_disp_q [5];
    logic        rs_sub_q  [5];
    logic [15:0] rs_vj_q   [5];
    logic [15:0] rs_vk_q   [5];
    logic [2:0]  rs_qj_q   [5];
    logic [2:0]  rs_qk_q   [5];

    logic        alu_busy_q;
    logic [1:0]  alu_cnt_q;
    logic [15:0] alu_res_q;
    logic [2:0]  alu_tag_q;
    logic        mul_busy_q;
    logic [1:0]  mul_cnt_q;
    logic [15:0] mul_res_q;
    logic [2:0]  mul_tag_q;

    // Decode of the offered instruction
    logic [15:0] instr;
    logic [1:0]  op;
    logic [3:0]  rd, rs1, rs2;
    logic        is_mul, is_nop;
    logic        unused_bits;

    assign instr       = imem_q[pc];
    assign op          = instr[15:14];
    assign rd          = instr[13:10];
    assign rs1         = instr[9:6];
    assign rs2         = instr[5:2];
    assign unused_bits = ^instr[1:0];
    assign is_mul      = (op == 2'b10);
    assign is_nop      = (op == 2'b11);

    // Lowest free station of the offered class
    logic       free_ok;
    logic [2:0] free_idx;
    logic [2:0] iss_tag;
    logic       do_issue;

    always_comb begin
        free_ok  = 1'b0;
        free_idx = 3'd0;
        if (is_mul) begin
            for (int i = 4; i >= 3; i--) begin
                if (!rs_busy_q[i]) begin
                    free_ok  = 1'b1;
                    free_idx = 3'(i);
                end
            end
        end else begin
            for (int i = 2; i >= 0; i--) begin
                if (!rs_busy_q[i]) begin
                    free_ok  = 1'b1;
                    free_idx = 3'(i);
                end
            end
        end
    end

    assign stall    = issue_en && !is_nop && !free_ok;
    assign do_issue = issue_en && !is_nop && free_ok;
    assign iss_tag  = free_idx + 3'd1;

    // CDB: multiplier wins, the adder holds its result until granted
    logic alu_done, mul_done, alu_grant;

    assign alu_done  = alu_busy_q && (alu_cnt_q == 2'd0);
    assign mul_done  = mul_busy_q && (mul_cnt_q == 2'd0);
    assign alu_grant = alu_done && !mul_done;
    assign cdb_valid = alu_done || mul_done;
    assign cdb_tag   = mul_done ? mul_tag_q : alu_tag_q;
    assign cdb_value = mul_done ? mul_res_q : alu_res_q;

    // Operand read; a tag being broadcast this cycle is forwarded
    logic [2:0]  t1, t2;
    logic [15:0] s1_v, s2_v;
    logic [2:0]  s1_q, s2_q;

    always_comb begin
        t1   = rtag_q[rs1];
        t2   = rtag_q[rs2];
        s1_v = rval_q[rs1];
        s1_q = 3'd0;
        s2_v = rval_q[rs2];
        s2_q = 3'd0;
        if (t1 != 3'd0) begin
            if (cdb_valid && cdb_tag == t1) begin
                s1_v = cdb_value;
            end else begin
                s1_v = 16'd0;
                s1_q = t1;
            end
        end
        if (t2 != 3'd0) begin
            if (cdb_valid && cdb_tag == t2) begin
                s2_v = cdb_value;
            end else begin
                s2_v = 16'd0;
                s2_q = t2;
            end
        end
    end

    // Dispatch selection
    logic       rdy [5];
    logic       alu_go, mul_go;
    logic [2:0] alu_idx, mul_idx;

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            rdy[i] = rs_busy_q[i] && !rs_disp_q[i] &&
                     (rs_qj_q[i] == 3'd0) && (rs_qk_q[i] == 3'd0);
        end
        alu_go  = 1'b0;
        alu_idx = 3'd0;
        for (int i = 2; i >= 0; i--) begin
            if (rdy[i]) begin
                alu_go  = !alu_busy_q;
                alu_idx = 3'(i);
            end
        end
        mul_go  = 1'b0;
        mul_idx = 3'd3;
        for (int i = 4; i >= 3; i--) begin
            if (rdy[i]) begin
                mul_go  = !mul_busy_q;
                mul_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (imem_we) begin
            imem_q[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) begin
                rval_q[k] <= 16'(k);
                rtag_q[k] <= 3'd0;
            end
            for (int i = 0; i < 5; i++) begin
                rs_busy_q[i] <= 1'b0;
                rs_disp_q[i] <= 1'b0;
                rs_sub_q[i]  <= 1'b0;
                rs_vj_q[i]   <= 16'd0;
                rs_vk_q[i]   <= 16'd0;
                rs_qj_q[i]   <= 3'd0;
                rs_qk_q[i]   <= 3'd0;
            end
            alu_busy_q <= 1'b0;
            alu_cnt_q  <= 2'd0;
            alu_res_q  <= 16'd0;
            alu_tag_q  <= 3'd0;
            mul_busy_q <= 1'b0;
            mul_cnt_q  <= 2'd0;
            mul_res_q  <= 16'd0;
            mul_tag_q  <= 3'd0;
        end else begin
            if (cdb_valid) begin
                for (int k = 0; k < 16; k++) begin
                    if (rtag_q[k] == cdb_tag) begin
                        rval_q[k] <= cdb_value;
                        rtag_q[k] <= 3'd0;
                    end
                end
                for (int i = 0; i < 5; i++) begin
                    if (rs_busy_q[i] && rs_qj_q[i] == cdb_tag) begin
                        rs_vj_q[i] <= cdb_value;
                        rs_qj_q[i] <= 3'd0;
                    end
                    if (rs_busy_q[i] && rs_qk_q[i] == cdb_tag) begin
                        rs_vk_q[i] <= cdb_value;
                        rs_qk_q[i] <= 3'd0;
                    end
                    if (cdb_tag == 3'(i + 1)) begin
                        rs_busy_q[i] <= 1'b0;
                        rs_disp_q[i] <= 1'b0;
                    end
                end
            end

            // Placed after the broadcast so a new rename wins on the same rd
            if (do_issue) begin
                rtag_q[rd]          <= iss_tag;
                rs_busy_q[free_idx] <= 1'b1;
                rs_disp_q[free_idx] <= 1'b0;
                rs_sub_q[free_idx]  <= (op == 2'b01);
                rs_vj_q[free_idx]   <= s1_v;
                rs_qj_q[free_idx]   <= s1_q;
                rs_vk_q[free_idx]   <= s2_v;
                rs_qk_q[free_idx]   <= s2_q;
            end

            if (alu_go) begin
                rs_disp_q[alu_idx] <= 1'b1;
                alu_busy_q <= 1'b1;
                alu_cnt_q  <= 2'd1;
                alu_tag_q  <= alu_idx + 3'd1;
                alu_res_q  <= rs_sub_q[alu_idx] ?
                              rs_vj_q[alu_idx] - rs_vk_q[alu_idx] :
                              rs_vj_q[alu_idx] + rs_vk_q[alu_idx];
            end else if (alu_busy_q) begin
                if (alu_cnt_q != 2'd0) begin
                    alu_cnt_q <= alu_cnt_q - 2'd1;
                end else if (alu_grant) begin
                    alu_busy_q <= 1'b0;
                end
            end

            if (mul_go) begin
                rs_disp_q[mul_idx] <= 1'b1;
                mul_busy_q <= 1'b1;
                mul_cnt_q  <= 2'd3;
                mul_tag_q  <= mul_idx + 3'd1;
                mul_res_q  <= rs_vj_q[mul_idx] * rs_vk_q[mul_idx];
            end else if (mul_busy_q) begin
                if (mul_cnt_q != 2'd0) begin
                    mul_cnt_q <= mul_cnt_q - 2'd1;
                end else begin
                    mul_busy_q <= 1'b0;
                end
            end
        end
    end

    assign dbg_rdata = rval_q[dbg_raddr];
    assign dbg_tag   = rtag_q[dbg_raddr];

endmodule

// File: tb/tb_tomasulo_core.sv
// Bench for tomasulo_core: directed timing scenarios plus a random program,
// with CDB results scored against an in-order architectural model.
module tb_tomasulo_core;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  pc = 4'd0;
    logic        issue_en = 1'b0;
    logic        imem_we = 1'b0;
    logic [3:0]  imem_waddr = 4'd0;
    logic [15:0] imem_wdata = 16'd0;
    logic        stall;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_value;
    logic [3:0]  dbg_raddr = 4'd0;
    logic [15:0] dbg_rdata;
    logic [2:0]  dbg_tag;

    always #5 clk1 = ~clk1;

    tomasulo_core dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .pc         (pc),
        .issue_en   (issue_en),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .stall      (stall),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_value  (cdb_value),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata),
        .dbg_tag    (dbg_tag)
    );

    typedef struct {
        logic [2:0]  tag;
        logic [15:0] val;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] ref_r   [16];
    logic [15:0] tb_imem [16];
    int          checks = 0;
    int          errors = 0;
    logic        st_seen;
    logic        pred_stall;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [1:0] o,
        input logic [3:0] d, input logic [3:0] a, input logic [3:0] b);
        return {o, d, a, b, 2'b00};
    endfunction

    function automatic bit tag_busy(input logic [2:0] t);
        foreach (sb[i]) if (sb[i].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    // Lowest free tag of the class, 0 when the class is full
    function automatic logic [2:0] pick_tag(input bit mul);
        if (mul) begin
            for (int t = 4; t <= 5; t++)
                if (!tag_busy(3'(t))) return 3'(t);
        end else begin
            for (int t = 1; t <= 3; t++)
                if (!tag_busy(3'(t))) return 3'(t);
        end
        return 3'd0;
    endfunction

    function automatic logic [15:0] model_op(input logic [1:0] o,
        input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (o)
            2'b00:   return a + b;
            2'b01:   return a - b;
            default: return p[15:0];
        endcase
    endfunction

    task automatic step(input logic [3:0] p, input logic en);
        logic [15:0] w;
        logic [2:0]  t;
        logic [15:0] v;
        bit          nop;
        @(negedge clk1);
        pc = p;
        issue_en = en;
        #1;
        w = tb_imem[p];
        nop = (w[15:14] == 2'b11);
        t = pick_tag(w[15:14] == 2'b10);
        pred_stall = en && !nop && (t == 3'd0);
        st_seen = stall;
        chk("stall", 32'(stall), 32'(pred_stall));
        @(posedge clk1);
        if (en && !nop && t != 3'd0) begin
            v = model_op(w[15:14], ref_r[w[9:6]], ref_r[w[5:2]]);
            ref_r[w[13:10]] = v;
            sb.push_back('{t, v});
        end
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk1);
        imem_we = 1'b1;
        imem_waddr = a;
        imem_wdata = d;
        @(posedge clk1);
        #1;
        imem_we = 1'b0;
        tb_imem[a] = d;
    endtask

    task automatic do_reset();
        @(negedge clk1);
        rst_n = 1'b0;
        issue_en = 1'b0;
        @(posedge clk1);
        #1;
        sb.delete();
        for (int k = 0; k < 16; k++) ref_r[k] = 16'(k);
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    task automatic rd(input string nm, input logic [3:0] a,
                      input logic [15:0] v, input logic [2:0] t);
        dbg_raddr = a;
        #1;
        chk({nm, "_val"}, 32'(dbg_rdata), 32'(v));
        chk({nm, "_tag"}, 32'(dbg_tag), 32'(t));
    endtask

    // Scoreboard monitor: each broadcast must match the pending result
    // of its tag; the tag is released at the edge ending the broadcast.
    initial begin
        forever begin
            int         idx;
            logic [2:0] t;
            @(negedge clk1);
            if (rst_n && cdb_valid) begin
                t = cdb_tag;
                idx = -1;
                foreach (sb[i]) if (sb[i].tag == t) idx = i;
                if (idx < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cdb_unexpected: got tag %0d, required no broadcast", t);
                end else begin
                    chk("cdb_value", 32'(cdb_value), 32'(sb[idx].val));
                    @(posedge clk1);
                    idx = -1;
                    foreach (sb[i]) if (sb[i].tag == t) idx = i;
                    if (idx >= 0) sb.delete(idx);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] p;
        logic       en;
        logic       hold;
        int         n;

        for (int i = 0; i < 16; i++) wr(4'(i), ins(2'b11, 0, 0, 0));
        do_reset();
        rd("rst_r5", 4'd5, 16'd5, 3'd0);
        chk("rst_cdb", 32'(cdb_valid), 0);
        chk("rst_stall", 32'(stall), 0);

        // Single ADD timing
        wr(4'd0, ins(2'b00, 4'd1, 4'd2, 4'd3));
        step(4'd0, 1'b1);
        rd("add_iss", 4'd1, 16'd1, 3'd1);
        step(4'd0, 1'b0);
        step(4'd0, 1'b0);
        chk("add_cdb_v", 32'(cdb_valid), 1);
        chk("add_cdb_t", 32'(cdb_tag), 1);
        chk("add_cdb_d", 32'(cdb_value), 5);
        step(4'd0, 1'b0);
        rd("add_wb", 4'd1, 16'd5, 3'd0);

        // Dependent MUL waits for the ADD's write edge
        do_reset();
        wr(4'd0, ins(2'b00, 4'd1, 4'd2, 4'd3));
        wr(4'd1, ins(2'b10, 4'd4, 4'd1, 4'd2));
        step(4'd0, 1'b1);
        step(4'd1, 1'b1);
        rd("dep_iss", 4'd4, 16'd4, 3'd4);
        repeat (6) step(4'd0, 1'b0);
        rd("dep_pre", 4'd4, 16'd4, 3'd4);
        chk("dep_cdb_t", 32'(cdb_tag), 4);
        chk("dep_cdb_d", 32'(cdb_value), 10);
        step(4'd0, 1'b0);
        rd("dep_wb", 4'd4, 16'd10, 3'd0);

        // ADD class full: fourth ADD stalls until tag 1 is freed
        do_reset();
        for (int i = 0; i < 4; i++)
            wr(4'(i), ins(2'b00, 4'(8 + i), 4'd1, 4'd2));
        step(4'd0, 1'b1);
        step(4'd1, 1'b1);
        step(4'd2, 1'b1);
        step(4'd3, 1'b1);
        chk("full_stall", 32'(st_seen), 1);
        step(4'd3, 1'b1);
        chk("free_stall", 32'(st_seen), 0);
        rd("reuse_tag", 4'd11, 16'd11, 3'd1);
        repeat (14) step(4'd0, 1'b0);
        rd("full_r11", 4'd11, 16'd3, 3'd0);

        // CDB priority: MUL and ADD finish together
        do_reset();
        wr(4'd0, ins(2'b10, 4'd6, 4'd2, 4'd3));
        wr(4'd1, ins(2'b00, 4'd7, 4'd4, 4'd5));
        step(4'd0, 1'b1);
        step(4'd0, 1'b0);
        step(4'd1, 1'b1);
        step(4'd0, 1'b0);
        step(4'd0, 1'b0);
        chk("pri_mul_t", 32'(cdb_tag), 4);
        chk("pri_mul_d", 32'(cdb_value), 6);
        rd("pri_add_wait", 4'd7, 16'd7, 3'd1);
        step(4'd0, 1'b0);
        rd("pri_mul_wb", 4'd6, 16'd6, 3'd0);
        chk("pri_add_t", 32'(cdb_tag), 1);
        chk("pri_add_d", 32'(cdb_value), 9);
        step(4'd0, 1'b0);
        rd("pri_add_wb", 4'd7, 16'd9, 3'd0);

        // Wraparound, then reset while a MUL is in flight
        do_reset();
        wr(4'd0, ins(2'b01, 4'd1, 4'd0, 4'd1));
        wr(4'd1, ins(2'b10, 4'd2, 4'd1, 4'd1));
        step(4'd0, 1'b1);
        step(4'd1, 1'b1);
        repeat (7) step(4'd0, 1'b0);
        rd("wrap_sub", 4'd1, 16'hFFFF, 3'd0);
        rd("wrap_mul", 4'd2, 16'h0001, 3'd0);
        step(4'd1, 1'b1);
        step(4'd0, 1'b0);
        step(4'd0, 1'b0);
        do_reset();
        rd("rst_r1", 4'd1, 16'd1, 3'd0);
        rd("rst_r2", 4'd2, 16'd2, 3'd0);
        chk("rst_mid_cdb", 32'(cdb_valid), 0);
        repeat (6) step(4'd0, 1'b0);
        rd("rst_after", 4'd2, 16'd2, 3'd0);

        // Random program, loaded while reset is held
        @(negedge clk1);
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++)
            wr(4'(i), ins(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))));
        do_reset();
        hold = 1'b0;
        p = 4'd0;
        en = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (!hold) begin
                p = 4'($urandom_range(0, 15));
                en = ($urandom_range(0, 3) != 0);
            end
            step(p, en);
            hold = pred_stall;
        end
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            step(4'd0, 1'b0);
            n++;
        end
        chk("drain", 32'(sb.size()), 0);
        for (int k = 0; k < 16; k++)
            rd("rand_reg", 4'(k), ref_r[k], 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
